mips_cpu_pc_unit: RTL and testbench

- Parametrised program-counter unit for the MIPS core.
- Implements architectural branch-delay-slot sequencing through a small state machine.
- Supports a stall hold, a configurable reset vector, and halt-on-jump-to-zero.
- Feeds the instruction-fetch address and exposes `pc_plus4` to the link and ALU paths.

---
 rtl/mips_cpu_pkg.sv | 21 ++
 rtl/mips_cpu_pc_target.sv | 50 +++++
 rtl/mips_cpu_pc_unit.sv | 116 +++++++++++
 tb/tb_mips_cpu_pc_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS core program-counter logic: PC state encoding
// and architectural address constants.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    DELAY  = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  localparam logic [31:0] MIPS_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] MIPS_HALT_ADDR    = 32'h0000_0000;

  // Byte offset between consecutive instructions.
  localparam int unsigned MIPS_INSTR_BYTES = 4;

  function automatic logic word_aligned(input logic [1:0] addr_lo);
    return (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/mips_cpu_pc_target.sv
// Redirect target selection for the PC unit: priority jump_reg > jump > taken
// branch, with J-type region splicing and I-type sign-extended word offsets.
module mips_cpu_pc_target
  import mips_cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_pc_plus4,
  input  logic              i_jump,
  input  logic              i_jump_reg,
  input  logic              i_branch,
  input  logic              i_branch_con,
  input  logic [25:0]       i_j_instr_addr,
  input  logic [15:0]       i_i_instr_addr,
  input  logic [ADDR_W-1:0] i_reg_addr,
  output logic [ADDR_W-1:0] o_target,
  output logic              o_redirect
);

  // Low 28 bits come from the J-type index; the rest from the delay-slot address.
  localparam logic [ADDR_W-1:0] J_MASK = ADDR_W'(28'hFFF_FFFF);

  logic signed [15:0] w_imm;
  logic [ADDR_W-1:0]  w_offset;
  logic [ADDR_W-1:0]  w_branch_tgt;
  logic [27:0]        w_jidx;
  logic [ADDR_W-1:0]  w_jump_tgt;

  assign w_imm        = i_i_instr_addr;
  assign w_offset     = ADDR_W'(w_imm) << 2;
  assign w_branch_tgt = i_pc_plus4 + w_offset;
  assign w_jidx       = {i_j_instr_addr, 2'b00};
  assign w_jump_tgt   = (i_pc_plus4 & ~J_MASK) | (ADDR_W'(w_jidx) & J_MASK);

  always_comb begin
    o_target   = '0;
    o_redirect = 1'b0;
    if (i_jump_reg) begin
      o_target   = i_reg_addr;
      o_redirect = 1'b1;
    end else if (i_jump) begin
      o_target   = w_jump_tgt;
      o_redirect = 1'b1;
    end else if (i_branch && i_branch_con) begin
      o_target   = w_branch_tgt;
      o_redirect = 1'b1;
    end
  end

endmodule

// File: rtl/mips_cpu_pc_unit.sv
// Program-counter unit with one architectural delay slot, stall hold and
// halt-on-redirect-to-HALT_ADDR. Optional PC_ALIGN_CHECK_EN adds a sticky misalign flag.
module mips_cpu_pc_unit
  import mips_cpu_pkg::*;
#(
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = MIPS_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = MIPS_HALT_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic              branch,
  input  logic              branch_con,
  input  logic [25:0]       j_instr_addr,
  input  logic [15:0]       i_instr_addr,
  input  logic [ADDR_W-1:0] reg_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              active,
  output logic              delay_slot
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic              misalign
`endif
);

  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VECTOR);
  localparam logic [ADDR_W-1:0] HALT_PC  = ADDR_W'(HALT_ADDR);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(MIPS_INSTR_BYTES);

  pc_state_t         r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_target;
  logic              r_active;
  logic              r_delay_slot;

  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_target;
  logic              w_redirect;
  logic              w_advance;
  logic              w_bad_target;

  assign w_pc_plus4 = r_pc + STEP;
  assign w_advance  = !stall && (r_state != HALTED);

  mips_cpu_pc_target #(
    .ADDR_W(ADDR_W)
  ) u_target (
    .i_pc_plus4    (w_pc_plus4),
    .i_jump        (jump),
    .i_jump_reg    (jump_reg),
    .i_branch      (branch),
    .i_branch_con  (branch_con),
    .i_j_instr_addr(j_instr_addr),
    .i_i_instr_addr(i_instr_addr),
    .i_reg_addr    (reg_addr),
    .o_target      (w_target),
    .o_redirect    (w_redirect)
  );

`ifdef PC_ALIGN_CHECK_EN
  logic r_misalign;
  assign w_bad_target = !word_aligned(r_target[1:0]);
  assign misalign     = r_misalign;
`else
  assign w_bad_target = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_state      <= SEQ;
      r_target     <= '0;
      r_active     <= 1'b1;
      r_delay_slot <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      r_misalign   <= 1'b0;
`endif
    end else if (w_advance) begin
      case (r_state)
        SEQ: begin
          r_pc <= w_pc_plus4;
          if (w_redirect) begin
            r_target     <= w_target;
            r_state      <= DELAY;
            r_delay_slot <= 1'b1;
          end
        end
        DELAY: begin
          // The latched target wins over any redirect issued from the delay slot.
          r_pc         <= r_target;
          r_delay_slot <= 1'b0;
          if ((r_target == HALT_PC) || w_bad_target) begin
            r_state  <= HALTED;
            r_active <= 1'b0;
          end else begin
            r_state <= SEQ;
          end
`ifdef PC_ALIGN_CHECK_EN
          if (w_bad_target) r_misalign <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign pc         = r_pc;
  assign pc_plus4   = w_pc_plus4;
  assign active     = r_active;
  assign delay_slot = r_delay_slot;

endmodule

// File: tb/tb_mips_cpu_pc_unit.sv
// Directed bench for mips_cpu_pc_unit: sequencing, delay slot, stall, priority,
// halt and reset-in-delay; misalign path when PC_ALIGN_CHECK_EN is defined.
module tb_mips_cpu_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        jump;
  logic        jump_reg;
  logic        branch;
  logic        branch_con;
  logic [25:0] j_instr_addr;
  logic [15:0] i_instr_addr;
  logic [31:0] reg_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        active;
  logic        delay_slot;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  mips_cpu_pc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .jump        (jump),
    .jump_reg    (jump_reg),
    .branch      (branch),
    .branch_con  (branch_con),
    .j_instr_addr(j_instr_addr),
    .i_instr_addr(i_instr_addr),
    .reg_addr    (reg_addr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .active      (active),
`ifdef PC_ALIGN_CHECK_EN
    .delay_slot  (delay_slot),
    .misalign    (misalign)
`else
    .delay_slot  (delay_slot)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    jump       = 1'b0;
    jump_reg   = 1'b0;
    branch     = 1'b0;
    branch_con = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    reset        = 1'b1;
    stall        = 1'b0;
    j_instr_addr = '0;
    i_instr_addr = '0;
    reg_addr     = '0;
    clear_ctrl();

    tick();
    check("reset_pc", pc, 32'hBFC0_0000);
    check("reset_active", {31'b0, active}, 32'd1);
    check("reset_ds", {31'b0, delay_slot}, 32'd0);
    check("reset_pc_plus4", pc_plus4, 32'hBFC0_0004);
`ifdef PC_ALIGN_CHECK_EN
    check("reset_misalign", {31'b0, misalign}, 32'd0);
`endif
    reset = 1'b0;

    tick(); check("seq_1", pc, 32'hBFC0_0004);
    tick(); check("seq_2", pc, 32'hBFC0_0008);
    tick(); check("seq_3", pc, 32'hBFC0_000C);
    tick(); check("seq_4", pc, 32'hBFC0_0010);

    // Taken branch at BFC00010, offset -4 words: BFC00014 - 0x10 = BFC00004.
    branch = 1'b1; branch_con = 1'b1; i_instr_addr = 16'hFFFC;
    tick();
    clear_ctrl();
    check("br_slot_pc", pc, 32'hBFC0_0014);
    check("br_slot_ds", {31'b0, delay_slot}, 32'd1);
    tick();
    check("br_target_pc", pc, 32'hBFC0_0004);
    check("br_target_ds", {31'b0, delay_slot}, 32'd0);

    // Stall held three cycles while in the delay slot.
    jump_reg = 1'b1; reg_addr = 32'hBFC0_0100;
    tick();
    clear_ctrl();
    check("stall_slot_pc", pc, 32'hBFC0_0008);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_pc", pc, 32'hBFC0_0008);
      check("stall_hold_ds", {31'b0, delay_slot}, 32'd1);
    end
    stall = 1'b0;
    tick();
    check("stall_release_pc", pc, 32'hBFC0_0100);
    check("stall_release_ds", {31'b0, delay_slot}, 32'd0);

    // Stall in sequential flow holds pc too.
    stall = 1'b1;
    tick();
    check("stall_seq_pc", pc, 32'hBFC0_0100);
    stall = 1'b0;

    // jump_reg beats jump; a branch in the delay slot is ignored.
    jump = 1'b1; jump_reg = 1'b1; j_instr_addr = 26'h3FF_FFFF; reg_addr = 32'hBFC0_0200;
    tick();
    clear_ctrl();
    check("prio_slot_pc", pc, 32'hBFC0_0104);
    branch = 1'b1; branch_con = 1'b1; i_instr_addr = 16'h0010;
    tick();
    clear_ctrl();
    check("prio_target_pc", pc, 32'hBFC0_0200);
    check("prio_target_ds", {31'b0, delay_slot}, 32'd0);
    tick();
    check("ds_branch_ignored_pc", pc, 32'hBFC0_0204);
    check("ds_branch_ignored_ds", {31'b0, delay_slot}, 32'd0);

    // J-type: upper nibble B from delay-slot address, index 0x123 << 2 = 0x48C.
    jump = 1'b1; j_instr_addr = 26'h000_0123;
    tick();
    clear_ctrl();
    check("j_slot_pc", pc, 32'hBFC0_0208);
    tick();
    check("j_target_pc", pc, 32'hB000_048C);

    // Branch with false condition is not a redirect.
    branch = 1'b1; branch_con = 1'b0; i_instr_addr = 16'h0100;
    tick();
    clear_ctrl();
    check("br_nt_pc", pc, 32'hB000_0490);
    check("br_nt_ds", {31'b0, delay_slot}, 32'd0);
    tick();
    check("br_nt_next_pc", pc, 32'hB000_0494);

    // Reset in the delay slot discards the pending target.
    jump_reg = 1'b1; reg_addr = 32'h1234_5678;
    tick();
    clear_ctrl();
    check("rst_ds_slot", {31'b0, delay_slot}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_ds_pc", pc, 32'hBFC0_0000);
    check("rst_ds_ds", {31'b0, delay_slot}, 32'd0);
    tick();
    check("rst_ds_after_pc", pc, 32'hBFC0_0004);

    // Walk to BFC00020, then jump_reg to zero halts.
    for (int i = 0; i < 7; i++) tick();
    check("walk_pc", pc, 32'hBFC0_0020);
    jump_reg = 1'b1; reg_addr = 32'h0;
    tick();
    clear_ctrl();
    check("halt_slot_pc", pc, 32'hBFC0_0024);
    check("halt_slot_active", {31'b0, active}, 32'd1);
    tick();
    check("halt_pc", pc, 32'h0);
    check("halt_active", {31'b0, active}, 32'd0);
    jump = 1'b1; j_instr_addr = 26'h0AB_CDEF; branch = 1'b1; branch_con = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("halt_hold_pc", pc, 32'h0);
    end
    clear_ctrl();
    check("halt_hold_active", {31'b0, active}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("halt_reset_pc", pc, 32'hBFC0_0000);
    check("halt_reset_active", {31'b0, active}, 32'd1);

`ifdef PC_ALIGN_CHECK_EN
    jump_reg = 1'b1; reg_addr = 32'hBFC0_0002;
    tick();
    clear_ctrl();
    check("mis_slot_pc", pc, 32'hBFC0_0004);
    check("mis_slot_flag", {31'b0, misalign}, 32'd0);
    tick();
    check("mis_pc", pc, 32'hBFC0_0002);
    check("mis_flag", {31'b0, misalign}, 32'd1);
    check("mis_active", {31'b0, active}, 32'd0);
    tick();
    check("mis_hold_pc", pc, 32'hBFC0_0002);
    check("mis_sticky", {31'b0, misalign}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
